iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle combinational ALU in the execute stage.
- Widens data to WIDTH bits and keeps the same opcode map.
- Replaces the combinational multiplier and divider with iterative radix-2 units.
- Wraps everything in a valid/ready handshake so the pipeline can stall on long operations.
- Sits between the ID/EX register and the EX/MEM register; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64, power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- op  input  4  opcode, same encoding as the existing ALU (0..c).
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- shamt  input  SHW  shift amount.
- kill  input  1  synchronous abort of the in-flight operation (branch flush).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  primary result (product low half or quotient for mul/div).
- result2  output  WIDTH  product high half or remainder; 0 for other ops.
- of  output  1  signed overflow (ops 5, 6 only).
- uof  output  1  unsigned carry/borrow (ops 5, 6 only).
- dz  output  1  divide by zero (op 4 only).
- equal  output  1  registered (x == y) of the accepted operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - in_ready=1 once released.
  - out_valid=0.
  - result, result2, of, uof, dz, equal all 0.
  - Iteration counter 0.
  - Reset mid-operation discards the operation silently.
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). A transfer occurs on an edge with in_valid && in_ready. The operands, op and shamt are captured on that edge.
- Single-cycle ops (0,1,2,5..c, and any undefined opcode):
  - Result is computed and registered at the accept edge; state goes to DONE.
  - out_valid is visible the cycle after accept (latency 1).
- Op semantics:
  - 0: SLL of y by shamt.
  - 1: SRA of y by shamt.
  - 2: SRL of y by shamt.
  - 5: ADD.
    - of = x,y same sign and result sign differs.
    - uof = carry out of bit WIDTH-1.
  - 6: SUB x-y.
    - of = x,y sign differs and result sign differs from x.
    - uof = borrow (x<y unsigned).
  - 7: AND. 8: OR. 9: XOR. a: NOR.
  - b: SLT, signed. c: SLTU. Both return a 1-bit result zero-extended.
  - Undefined opcodes (d..f): result=0, all flags 0.
- Op 3, MUL (signed x signed):
  - IDLE->MUL.
  - Shift-add on the magnitudes, one bit per cycle, WIDTH iterations, then sign correction.
  - After WIDTH cycles, state goes to DONE with {result2,result} = 2*WIDTH-bit signed product.
  - out_valid is visible WIDTH cycles after accept.
- Op 4, DIV (unsigned):
  - IDLE->DIV.
  - Restoring division, one quotient bit per cycle, WIDTH iterations.
  - result = quotient, result2 = remainder.
  - Latency WIDTH.
  - y==0: iterate normally and produce quotient all-ones, remainder = x, dz=1.
- DONE:
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops and state returns to IDLE.
  - in_ready rises the cycle after the handoff, so back-to-back throughput is one op per 2 cycles minimum.
- kill (synchronous):
  - In MUL, DIV or DONE: next state is IDLE and out_valid=0; no result is delivered.
  - In IDLE, kill beats in_valid: no accept.
- Flags not defined for an op are 0.
- Outputs of a retired op keep their values in IDLE until the next accept; only out_valid qualifies them.

Optional Feature:
- Macro: ITER_ALU_SDIV_EN.
- Defined:
  - Opcode d = signed divide.
  - Magnitudes are divided.
  - Quotient is negated if the signs differ; remainder takes the sign of x.
  - Latency WIDTH.
  - y==0 gives quotient = -1 if x>=0 else 1, remainder = x, dz=1.
  - Most-negative / -1 gives quotient = most-negative, remainder 0, of=1.
- Not defined: opcode d is undefined (result 0, latency 1).

Test Plan:
- Reset mid-DIV (WIDTH=32, x=100, y=7, rst_n pulsed low at cycle 5) -> out_valid=0, in_ready=1 after release, all outputs 0.
- ADD x=0x7FFFFFFF, y=1 -> out_valid at cycle+1, result=0x80000000, of=1, uof=0; ADD 0xFFFFFFFF+1 -> result=0, of=0, uof=1.
- MUL x=0xFFFFFFFE (-2), y=3 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFA, result2=0xFFFFFFFF.
- DIV x=100, y=7 -> result=14, result2=2, dz=0; DIV x=5, y=0 -> result=0xFFFFFFFF, result2=5, dz=1.
- Hold out_ready=0 for 10 cycles after a SRA of y=0x80000000 by shamt=4 -> result stays 0xF8000000, in_ready=0 throughout; then out_ready=1 -> in_ready=1 the next cycle.
- kill asserted 10 cycles into a MUL -> no out_valid ever for that op; the next SLTU x=1, y=2 -> result=1.

Source files
------------

// File: rtl/iter_alu.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic ops, iterative radix-2 MUL and DIV.
// Optional macro ITER_ALU_SDIV_EN adds opcode d as a signed divide.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [SHW-1:0]   shamt,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result2,
   output logic             of,
   output logic             uof,
   output logic             dz,
   output logic             equal
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mc;
   logic               neg_q, neg_r, ovf;

   logic               sdiv_op, sgn, xs, ys;
   logic [WIDTH-1:0]   ax, ay, mul_m, div_m;
   logic [2*WIDTH-1:0] mul_in, div_in, mul_nx, div_nx, mul_fin;
   logic [WIDTH-1:0]   q_mag, r_mag;
   logic [WIDTH+1:0]   alu_res;

   // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {sum, p[WIDTH-1:1]};
   endfunction

   // One restoring step on {remainder, dividend/quotient}; quotient bits enter from the right.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                   input logic [WIDTH-1:0]   d);
      logic [WIDTH:0] r;
      logic           qb;
      r  = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]};
      qb = (r >= {1'b0, d});
      if (qb) r = r - {1'b0, d};
      return {r[WIDTH-1:0], rq[WIDTH-2:0], qb};
   endfunction

   function automatic logic [WIDTH+1:0] alu1(input logic [3:0]       o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [SHW-1:0]   s);
      logic [WIDTH-1:0] r;
      logic [WIDTH:0]   t;
      logic             v, c;
      r = '0;
      t = '0;
      v = 1'b0;
      c = 1'b0;
      case (o)
         4'h0: r = b << s;
         4'h1: r = $signed(b) >>> s;
         4'h2: r = b >> s;
         4'h5: begin
            t = {1'b0, a} + {1'b0, b};
            r = t[WIDTH-1:0];
            c = t[WIDTH];
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         4'h6: begin
            t = {1'b0, a} - {1'b0, b};
            r = t[WIDTH-1:0];
            c = t[WIDTH];
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         4'h7: r = a & b;
         4'h8: r = a | b;
         4'h9: r = a ^ b;
         4'ha: r = ~(a | b);
         4'hb: r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'hc: r = {{(WIDTH-1){1'b0}}, a < b};
         default: ;
      endcase
      return {v, c, r};
   endfunction

`ifdef ITER_ALU_SDIV_EN
   assign sdiv_op = (op == 4'hd);
`else
   assign sdiv_op = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // The first iteration runs on the accept edge from the live operands, so WIDTH steps fit in WIDTH cycles.
   always_comb begin
      sgn = (op == 4'h3) || sdiv_op;
      xs  = sgn && x[WIDTH-1];
      ys  = sgn && y[WIDTH-1];
      ax  = xs ? -x : x;
      ay  = ys ? -y : y;
      if (state == IDLE) begin
         mul_in = {{WIDTH{1'b0}}, ay};
         mul_m  = ax;
         div_in = {{WIDTH{1'b0}}, ax};
         div_m  = ay;
      end else begin
         mul_in = acc;
         mul_m  = mc;
         div_in = acc;
         div_m  = mc;
      end
      mul_nx  = mul_step(mul_in, mul_m);
      div_nx  = div_step(div_in, div_m);
      mul_fin = neg_q ? -mul_nx : mul_nx;
      q_mag   = div_nx[WIDTH-1:0];
      r_mag   = div_nx[2*WIDTH-1:WIDTH];
      alu_res = alu1(op, x, y, shamt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         mc      <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         ovf     <= 1'b0;
         result  <= '0;
         result2 <= '0;
         of      <= 1'b0;
         uof     <= 1'b0;
         dz      <= 1'b0;
         equal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && !kill) begin
                  equal <= (x == y);
                  cnt   <= CW'(1);
                  neg_q <= xs ^ ys;
                  if (op == 4'h3) begin
                     acc   <= mul_nx;
                     mc    <= ax;
                     state <= MUL;
                  end else if (op == 4'h4 || sdiv_op) begin
                     acc   <= div_nx;
                     mc    <= ay;
                     neg_r <= xs;
                     ovf   <= sdiv_op && (x == MOST_NEG) && (&y);
                     state <= DIV;
                  end else begin
                     {of, uof, result} <= alu_res;
                     result2 <= '0;
                     dz      <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            MUL: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  acc <= mul_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     {result2, result} <= mul_fin;
                     of    <= 1'b0;
                     uof   <= 1'b0;
                     dz    <= 1'b0;
                     state <= DONE;
                  end
               end
            end
            DIV: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  acc <= div_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     result  <= neg_q ? -q_mag : q_mag;
                     result2 <= neg_r ? -r_mag : r_mag;
                     of      <= ovf;
                     uof     <= 1'b0;
                     dz      <= (mc == '0);
                     state   <= DONE;
                  end
               end
            end
            default: begin
               if (kill || out_ready) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Directed scoreboard bench for iter_alu at WIDTH=32.
module tb_iter_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         kill = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   op = '0;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic [4:0]   shamt = '0;
   logic         in_ready, out_valid, of, uof, dz, equal;
   logic [W-1:0] result, result2;

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] r2;
      logic         of;
      logic         uof;
      logic         dz;
      logic         eq;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .x(x), .y(y), .shamt(shamt), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result2(result2), .of(of), .uof(uof), .dz(dz), .equal(equal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [4:0] s);
      exp_t        e;
      longint      sa, sb, p;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.r = '0; e.r2 = '0; e.of = 1'b0; e.uof = 1'b0; e.dz = 1'b0;
      e.eq = (a == b);
      e.lat = 1;
      case (o)
         4'h0: e.r = b << s;
         4'h1: e.r = 32'(sb >>> s);
         4'h2: e.r = b >> s;
         4'h3: begin p = sa * sb; {e.r2, e.r} = p; e.lat = W; end
         4'h4: begin
            e.lat = W;
            if (b == 0) begin e.r = '1; e.r2 = a; e.dz = 1'b1; end
            else begin e.r = a / b; e.r2 = a % b; end
         end
         4'h5: begin
            t = {32'd0, a} + {32'd0, b};
            e.r = t[31:0]; e.uof = t[32];
            p = sa + sb;
            e.of = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         end
         4'h6: begin
            t = {32'd0, a} - {32'd0, b};
            e.r = t[31:0]; e.uof = (a < b);
            p = sa - sb;
            e.of = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         end
         4'h7: e.r = a & b;
         4'h8: e.r = a | b;
         4'h9: e.r = a ^ b;
         4'ha: e.r = ~(a | b);
         4'hb: e.r = (sa < sb) ? 32'd1 : 32'd0;
         4'hc: e.r = (a < b) ? 32'd1 : 32'd0;
`ifdef ITER_ALU_SDIV_EN
         4'hd: begin
            e.lat = W;
            if (b == 0) begin
               e.r = (sa >= 0) ? 32'hFFFF_FFFF : 32'd1; e.r2 = a; e.dz = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.r = 32'h8000_0000; e.r2 = '0; e.of = 1'b1;
            end else begin
               e.r = 32'(sa / sb); e.r2 = 32'(sa % sb);
            end
         end
`endif
         default: ;
      endcase
      return e;
   endfunction

   // Drives one request and returns #1 after its accept edge.
   task automatic start(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] s);
      @(negedge clk);
      check("in_ready_before", {63'd0, in_ready}, 64'd1);
      op = o; x = a; y = b; shamt = s; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input bit hold);
      int   lat;
      exp_t e;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      e = sb_q.pop_front();
      check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, ".lat"}, 64'(lat), 64'(e.lat));
      check({tag, ".res"}, {32'd0, result}, {32'd0, e.r});
      check({tag, ".res2"}, {32'd0, result2}, {32'd0, e.r2});
      check({tag, ".flags"}, {60'd0, of, uof, dz, equal}, {60'd0, e.of, e.uof, e.dz, e.eq});
      if (!hold) begin
         @(posedge clk);
         #1 check({tag, ".handoff"}, {62'd0, out_valid, in_ready}, 64'b01);
      end
   endtask

   task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [4:0] s);
      sb_q.push_back(model(o, a, b, s));
      start(o, a, b, s);
      wait_result(tag, 1'b0);
   endtask

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #1 check("rst.outs", {out_valid, of, uof, dz, equal, result, result2}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("rst.in_ready", {63'd0, in_ready}, 64'd1);

      run("add_of", 4'h5, 32'h7FFF_FFFF, 32'h1, 5'd0);
      run("add_carry", 4'h5, 32'hFFFF_FFFF, 32'h1, 5'd0);

      // Reset arriving mid-divide must clear everything and deliver nothing.
      start(4'h4, 32'd100, 32'd7, 5'd0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rstdiv.outs", {out_valid, of, uof, dz, equal, result, result2}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("rstdiv.in_ready", {63'd0, in_ready}, 64'd1);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1 seen |= out_valid; end
      check("rstdiv.no_valid", {63'd0, seen}, 64'd0);

      run("mul_neg", 4'h3, 32'hFFFF_FFFE, 32'd3, 5'd0);
      run("mul_minmin", 4'h3, 32'h8000_0000, 32'h8000_0000, 5'd0);
      run("mul_negneg", 4'h3, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 5'd0);
      run("div", 4'h4, 32'd100, 32'd7, 5'd0);
      run("div_zero", 4'h4, 32'd5, 32'd0, 5'd0);
      run("div_big", 4'h4, 32'hFFFF_FFFF, 32'd1, 5'd0);
      run("div_small", 4'h4, 32'd7, 32'd100, 5'd0);
      run("sub_borrow", 4'h6, 32'd0, 32'd1, 5'd0);
      run("sub_of", 4'h6, 32'h8000_0000, 32'd1, 5'd0);
      run("add_both", 4'h5, 32'h8000_0000, 32'h8000_0000, 5'd0);
      run("slt", 4'hb, 32'hFFFF_FFFF, 32'd1, 5'd0);
      run("sltu", 4'hc, 32'hFFFF_FFFF, 32'd1, 5'd0);
      run("sll", 4'h0, 32'd0, 32'h8000_0001, 5'd31);
      run("srl", 4'h2, 32'd0, 32'h8000_0000, 5'd4);
      run("nor_eq", 4'ha, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 5'd0);
      run("undef_e", 4'he, 32'h1234, 32'h1234, 5'd3);
      run("undef_f", 4'hf, 32'hFFFF_FFFF, 32'd0, 5'd1);
`ifdef ITER_ALU_SDIV_EN
      run("sdiv", 4'hd, 32'hFFFF_FF9C, 32'd7, 5'd0);
      run("sdiv_zero_neg", 4'hd, 32'hFFFF_FFFB, 32'd0, 5'd0);
      run("sdiv_zero_pos", 4'hd, 32'd5, 32'd0, 5'd0);
      run("sdiv_ovf", 4'hd, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
`else
      run("undef_d", 4'hd, 32'd100, 32'd7, 5'd0);
`endif
      for (int i = 0; i < 10; i++) begin
         run("rand", 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end

      // Hold a result with out_ready low.
      @(negedge clk) out_ready = 1'b0;
      sb_q.push_back(model(4'h1, 32'd0, 32'h8000_0000, 5'd4));
      start(4'h1, 32'd0, 32'h8000_0000, 5'd4);
      wait_result("sra_hold", 1'b1);
      seen = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1 seen &= (result == 32'hF800_0000) && out_valid && !in_ready;
      end
      check("hold.stable", {63'd0, seen}, 64'd1);
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 check("hold.release", {62'd0, out_valid, in_ready}, 64'b01);

      // Kill ten cycles into a multiply.
      start(4'h3, 32'd1234, 32'd5678, 5'd0);
      repeat (9) @(posedge clk);
      @(negedge clk) kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1 seen |= out_valid; end
      check("kill_mul.no_valid", {62'd0, seen, in_ready}, 64'b01);
      run("sltu_after_kill", 4'hc, 32'd1, 32'd2, 5'd0);

      // Kill in IDLE wins over in_valid.
      @(negedge clk);
      op = 4'h5; x = 32'd1; y = 32'd1; in_valid = 1'b1; kill = 1'b1;
      @(posedge clk);
      #1 begin in_valid = 1'b0; kill = 1'b0; end
      check("kill_idle", {62'd0, out_valid, in_ready}, 64'b01);

      // Kill while a result waits in DONE.
      @(negedge clk) out_ready = 1'b0;
      sb_q.push_back(model(4'h9, 32'hAAAA_0000, 32'h0000_5555, 5'd0));
      start(4'h9, 32'hAAAA_0000, 32'h0000_5555, 5'd0);
      wait_result("xor_done", 1'b1);
      @(negedge clk) kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      check("kill_done", {62'd0, out_valid, in_ready}, 64'b01);
      check("kill_done.keep", {32'd0, result}, 64'hAAAA_5555);
      out_ready = 1'b1;

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
